// File: rtl/wb_bus_exerciser.sv
// wb_bus_exerciser: sequenced Wishbone master for bus bring-up (single, fill, verify, fill+verify)
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start, mode, man_*  launch an operation; man_* drive the single-transaction mode
//   wishbone_*          classic Wishbone master interface
//   busy, done, pass    operation status
//   err_count           mismatches plus timeouts (saturating), timeout_flag = any timeout
//   last_data           data of the last acknowledged read
//   err_addr/err_expected/err_actual  first failure of the operation when
//                       WB_EXERCISER_ERRCAP_EN is defined, otherwise tied to zero
module wb_bus_exerciser #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    SEL_WIDTH    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    ADDR_STEP    = 1,
    parameter int                    NUM_WORDS    = 16,
    parameter logic [31:0]           PATTERN_SEED = 32'hA5A5_0000,
    parameter int                    TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] man_addr,
    input  logic [DATA_WIDTH-1:0] man_data,
    input  logic                  man_we,
    input  logic [SEL_WIDTH-1:0]  man_sel,
    output logic [ADDR_WIDTH-1:0] wishbone_addr_o,
    output logic [DATA_WIDTH-1:0] wishbone_data_o,
    output logic                  wishbone_we_o,
    output logic [SEL_WIDTH-1:0]  wishbone_sel_o,
    output logic                  wishbone_stb_o,
    output logic                  wishbone_cyc_o,
    input  logic [DATA_WIDTH-1:0] wishbone_data_i,
    input  logic                  wishbone_ack_i,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic                  timeout_flag,
    output logic [DATA_WIDTH-1:0] last_data,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [DATA_WIDTH-1:0] err_expected,
    output logic [DATA_WIDTH-1:0] err_actual
);
    localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2, DONE = 2'd3;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IW-1:0] i);
        return BASE_ADDR + ADDR_WIDTH'(i) * ADDR_WIDTH'(ADDR_STEP);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [IW-1:0] i);
        return DATA_WIDTH'(PATTERN_SEED ^ 32'(i));
    endfunction

    logic [1:0]            state_q, state_d, mode_q, mode_d;
    logic [IW-1:0]         idx_q, idx_d, idx_n;
    logic [TW-1:0]         wait_q, wait_d;
    logic                  busy_q, busy_d, done_q, done_d, to_q, to_d, we_q, we_d;
    logic [15:0]           err_q, err_d;
    logic [DATA_WIDTH-1:0] last_q, last_d, data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  req, accept, tout, mism, fin, last_word, to_read, more, single;

    assign req       = state_q == REQ;
    assign accept    = (state_q == IDLE || state_q == DONE) && start;
    assign tout      = req && !wishbone_ack_i && wait_q == TW'(TIMEOUT - 1);
    // data_q carries the expected pattern during block reads
    assign mism      = req && wishbone_ack_i && !we_q && mode_q != 2'b00 && wishbone_data_i != data_q;
    assign fin       = req && (wishbone_ack_i || tout);
    assign last_word = idx_q == IW'(NUM_WORDS - 1);
    // fill+verify switches to the read phase after the last write
    assign to_read   = mode_q == 2'b11 && we_q && last_word;
    assign more      = mode_q != 2'b00 && (!last_word || to_read);
    assign idx_n     = to_read ? '0 : idx_q + 1'b1;
    assign single    = mode == 2'b00;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        busy_d  = busy_q;
        done_d  = done_q;
        to_d    = to_q;
        we_d    = we_q;
        err_d   = err_q;
        last_d  = last_q;
        data_d  = data_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        if (accept) begin
            state_d = REQ;
            mode_d  = mode;
            idx_d   = '0;
            wait_d  = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            to_d    = 1'b0;
            err_d   = '0;
            addr_d  = single ? man_addr : word_addr('0);
            data_d  = single ? man_data : pattern('0);
            we_d    = single ? man_we : mode != 2'b10;
            sel_d   = single ? man_sel : '1;
        end else if (state_q == GAP) begin
            state_d = REQ;
        end else if (req) begin
            wait_d = fin ? '0 : wait_q + 1'b1;
            if (wishbone_ack_i && !we_q) last_d = wishbone_data_i;
            if ((tout || mism) && err_q != 16'hFFFF) err_d = err_q + 1'b1;
            if (tout) to_d = 1'b1;
            if (fin) begin
                state_d = more ? GAP : DONE;
                busy_d  = more;
                done_d  = !more;
            end
            if (fin && more) begin
                idx_d  = idx_n;
                we_d   = we_q && !to_read;
                addr_d = word_addr(idx_n);
                data_d = pattern(idx_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            to_q    <= to_d;
            we_q    <= we_d;
            err_q   <= err_d;
            last_q  <= last_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
        end
    end

    assign wishbone_addr_o = addr_q;
    assign wishbone_data_o = data_q;
    assign wishbone_we_o   = we_q;
    assign wishbone_sel_o  = sel_q;
    assign wishbone_stb_o  = req;
    assign wishbone_cyc_o  = req;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = done_q && err_q == '0;
    assign err_count       = err_q;
    assign timeout_flag    = to_q;
    assign last_data       = last_q;

`ifdef WB_EXERCISER_ERRCAP_EN
    logic                  cap_q, cap_d;
    logic [ADDR_WIDTH-1:0] ea_q, ea_d;
    logic [DATA_WIDTH-1:0] ee_q, ee_d, eact_q, eact_d;

    always_comb begin
        cap_d  = cap_q;
        ea_d   = ea_q;
        ee_d   = ee_q;
        eact_d = eact_q;
        if (accept) begin
            cap_d  = 1'b0;
            ea_d   = '0;
            ee_d   = '0;
            eact_d = '0;
        end else if ((tout || mism) && !cap_q) begin
            cap_d  = 1'b1;
            ea_d   = addr_q;
            ee_d   = data_q;
            eact_d = tout ? '0 : wishbone_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q  <= 1'b0;
            ea_q   <= '0;
            ee_q   <= '0;
            eact_q <= '0;
        end else begin
            cap_q  <= cap_d;
            ea_q   <= ea_d;
            ee_q   <= ee_d;
            eact_q <= eact_d;
        end
    end

    assign err_addr     = ea_q;
    assign err_expected = ee_q;
    assign err_actual   = eact_q;
`else
    assign err_addr     = '0;
    assign err_expected = '0;
    assign err_actual   = '0;
`endif
endmodule
